pc_sequencer: RTL and testbench

Front-end controller for the program counter register. Each cycle it decides whether the PC advances and to what address (sequential, branch, jump, or a pending redirect). It also generates the IF/ID and ID/EX stall and flush controls, handling load-use hazards, instruction-memory wait states and halt. It sits between the hazard/branch logic and the PC register, driving that register's `next_pc` and `pc_write` inputs.

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/sat_counter32.sv | 21 ++
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM encoding, default
// sequential increment and the counter saturation value.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_REDIR_WAIT = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

    localparam int          INSTR_BYTES_DEF = 4;
    localparam logic [31:0] CNT_SAT         = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the hazard/branch logic, the PC register and the sequencer.
// The master side is the sequencer itself; the slave side is its environment.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              load_use_hazard;
    logic              halt;
    logic              imem_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] next_pc;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic [31:0]       stall_count;
    logic [31:0]       redirect_count;
    logic              halted;

    modport master (
        input  pc, branch_taken, branch_target, jump, jump_target,
               load_use_hazard, halt, imem_ready,
        output imem_req, next_pc, pc_write, if_id_write, if_id_flush,
               id_ex_bubble, stall_count, redirect_count, halted
    );

    modport slave (
        output pc, branch_taken, branch_target, jump, jump_target,
               load_use_hazard, halt, imem_ready,
        input  imem_req, next_pc, pc_write, if_id_write, if_id_flush,
               id_ex_bubble, stall_count, redirect_count, halted
    );
endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32
    import pc_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en,
    output logic [31:0] count
);
    logic [31:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_SAT)) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter front-end controller: chooses the next PC, and drives the
// IF/ID and ID/EX stall/flush controls for redirects, hazards, wait states and halt.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    pc_sequencer_if.master bus
);
    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pend_target_reg, pend_target_next;
    logic [ADDR_W-1:0] seq_pc, redirect_target, next_pc;
    logic              redirect, pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic              imem_req, stall_en, redirect_en;

    assign seq_pc          = bus.pc + ADDR_W'(INSTR_BYTES);
    assign redirect        = bus.jump | bus.branch_taken;
    assign redirect_target = bus.jump ? bus.jump_target : bus.branch_target;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_BOOT;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pend_target_reg <= pend_target_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pend_target_next = pend_target_reg;
        next_pc          = seq_pc;
        pc_write         = 1'b0;
        if_id_write      = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_bubble     = 1'b0;
        imem_req         = 1'b0;
        redirect_en      = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_next   = ST_RUN;
            end
            ST_RUN: begin
                imem_req = 1'b1;
                if (bus.halt) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_next   = ST_HALT;
                end else if (redirect) begin
                    if_id_flush = 1'b1;
                    redirect_en = 1'b1;
                    if (bus.imem_ready) begin
                        pc_write    = 1'b1;
                        next_pc     = redirect_target;
                        if_id_write = 1'b1;
                    end else begin
                        // Fetch still busy: remember where to go once it completes
                        pend_target_next = redirect_target;
                        state_next       = ST_REDIR_WAIT;
                    end
                end else if (bus.load_use_hazard || !bus.imem_ready) begin
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
            end
            ST_REDIR_WAIT: begin
                imem_req     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (bus.halt) begin
                    pend_target_next = '0;
                    state_next       = ST_HALT;
                end else if (bus.imem_ready) begin
                    pc_write   = 1'b1;
                    next_pc    = pend_target_reg;
                    state_next = ST_RUN;
                end
            end
            default: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        endcase
    end

    assign stall_en = ((state_reg == ST_RUN) || (state_reg == ST_REDIR_WAIT)) && !pc_write;

    sat_counter32 u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (stall_en),
        .count   (bus.stall_count)
    );

    sat_counter32 u_redir_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (redirect_en),
        .count   (bus.redirect_count)
    );

    assign bus.next_pc      = next_pc;
    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.imem_req     = imem_req;
    assign bus.halted       = (state_reg == ST_HALT);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized check of pc_sequencer against a rule-level model
// that also plays the role of the PC register.
module tb_pc_sequencer;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(.ADDR_W(32), .INSTR_BYTES(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: which phase the front end is in, as plain flags.
    bit          m_boot, m_wait, m_halt;
    logic [31:0] m_pend, m_stall, m_redir;
    logic        e_req, e_pw, e_ifw, e_fl, e_bub, e_halted;
    logic [31:0] e_npc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void predict();
        e_npc = bus.pc + 32'd4;
        e_req = 1'b1; e_pw = 1'b0; e_ifw = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_halted = 1'b0;
        if (m_halt) begin
            e_req = 1'b0; e_fl = 1'b1; e_bub = 1'b1; e_halted = 1'b1;
        end else if (m_boot) begin
            e_req = 1'b0; e_fl = 1'b1; e_bub = 1'b1;
        end else if (m_wait) begin
            e_fl = 1'b1; e_bub = 1'b1;
            if (!bus.halt && bus.imem_ready) begin
                e_pw = 1'b1; e_npc = m_pend;
            end
        end else if (bus.halt) begin
            e_fl = 1'b1; e_bub = 1'b1;
        end else if (bus.jump || bus.branch_taken) begin
            e_fl = 1'b1;
            if (bus.imem_ready) begin
                e_pw = 1'b1; e_ifw = 1'b1;
                e_npc = bus.jump ? bus.jump_target : bus.branch_target;
            end
        end else if (bus.load_use_hazard || !bus.imem_ready) begin
            e_bub = 1'b1;
        end else begin
            e_pw = 1'b1; e_ifw = 1'b1;
        end
    endfunction

    // Applied after a clock edge, with the inputs that were present at the edge.
    function automatic void advance();
        bit active;
        active = !m_boot && !m_halt;
        if (active && !e_pw && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (active && !m_wait && !bus.halt && (bus.jump || bus.branch_taken) && m_redir != 32'hFFFF_FFFF)
            m_redir = m_redir + 32'd1;
        if (m_halt) begin
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (bus.halt) begin
            m_halt = 1'b1; m_wait = 1'b0; m_pend = '0;
        end else if (m_wait) begin
            if (bus.imem_ready) m_wait = 1'b0;
        end else if ((bus.jump || bus.branch_taken) && !bus.imem_ready) begin
            m_wait = 1'b1;
            m_pend = bus.jump ? bus.jump_target : bus.branch_target;
        end
        if (e_pw) bus.pc = e_npc;
    endfunction

    task automatic check_outputs(input string pfx);
        predict();
        chk({pfx, "_imem_req"},     {31'd0, bus.imem_req},     {31'd0, e_req});
        chk({pfx, "_next_pc"},      bus.next_pc,               e_npc);
        chk({pfx, "_pc_write"},     {31'd0, bus.pc_write},     {31'd0, e_pw});
        chk({pfx, "_if_id_write"},  {31'd0, bus.if_id_write},  {31'd0, e_ifw});
        chk({pfx, "_if_id_flush"},  {31'd0, bus.if_id_flush},  {31'd0, e_fl});
        chk({pfx, "_id_ex_bubble"}, {31'd0, bus.id_ex_bubble}, {31'd0, e_bub});
        chk({pfx, "_halted"},       {31'd0, bus.halted},       {31'd0, e_halted});
    endtask

    task automatic step(input string tag, input bit bt, input logic [31:0] btg, input bit j,
                        input logic [31:0] jtg, input bit luh, input bit h, input bit rdy);
        bus.branch_taken = bt; bus.branch_target = btg;
        bus.jump = j; bus.jump_target = jtg;
        bus.load_use_hazard = luh; bus.halt = h; bus.imem_ready = rdy;
        #1;
        check_outputs(tag);
        $display("[TB] %s pc=0x%08h next_pc=0x%08h pc_write=%0b stall=%0d redir=%0d",
                 tag, bus.pc, bus.next_pc, bus.pc_write, bus.stall_count, bus.redirect_count);
        @(posedge clock);
        #1;
        advance();
        chk({tag, "_stall_count"},    bus.stall_count,    m_stall);
        chk({tag, "_redirect_count"}, bus.redirect_count, m_redir);
    endtask

    task automatic do_reset(input string tag, input bit wait_edge);
        reset_n = 1'b0;
        if (wait_edge) @(posedge clock);
        #1;
        m_boot = 1'b1; m_wait = 1'b0; m_halt = 1'b0;
        m_pend = '0; m_stall = '0; m_redir = '0;
        check_outputs(tag);
        chk({tag, "_stall_count"},    bus.stall_count,    32'd0);
        chk({tag, "_redirect_count"}, bus.redirect_count, 32'd0);
        $display("[TB] %s reset applied", tag);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        bus.pc = '0; bus.branch_taken = 0; bus.branch_target = '0; bus.jump = 0;
        bus.jump_target = '0; bus.load_use_hazard = 0; bus.halt = 0; bus.imem_ready = 0;
        do_reset("por", 1'b1);

        // Boot then straight-line fetch: 0x4, 0x8, 0xC
        step("boot", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 0, 0, 0, 1);
        chk("seq_pc_final", bus.pc, 32'h0000_000C);

        // Two-cycle load-use stall holds PC
        bus.pc = 32'h40;
        step("luh1", 0, 0, 0, 0, 1, 0, 1);
        step("luh2", 0, 0, 0, 0, 1, 0, 1);
        chk("luh_pc_held", bus.pc, 32'h40);
        chk("luh_stall_count", bus.stall_count, 32'd2);

        // Jump beats branch, single redirect
        step("jmp_br", 1, 32'h200, 1, 32'h100, 0, 0, 1);
        chk("jmp_br_pc", bus.pc, 32'h100);
        chk("jmp_br_redirects", bus.redirect_count, 32'd1);

        // Branch during fetch wait; jump inside the wait is ignored
        step("brw0", 1, 32'h80, 0, 0, 0, 0, 0);
        step("brw1", 0, 0, 1, 32'h300, 1, 0, 0);
        step("brw2", 0, 0, 1, 32'h300, 0, 0, 0);
        step("brw3", 0, 0, 0, 0, 0, 0, 1);
        chk("brw_pc", bus.pc, 32'h80);

        // Sequential wrap at the top of the address space
        bus.pc = 32'hFFFF_FFFC;
        step("wrap", 0, 0, 0, 0, 0, 0, 1);
        chk("wrap_pc", bus.pc, 32'h0);

        // Stall counter pinned at its ceiling
        force dut.u_stall_cnt.count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.count_reg;
        m_stall = 32'hFFFF_FFFF;
        step("sat1", 0, 0, 0, 0, 1, 0, 1);
        step("sat2", 0, 0, 0, 0, 0, 0, 0);

        // Halt is sticky; asynchronous reset is the way out
        step("halt", 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++)
            step("halted", 1, 32'h500, 1, 32'h600, 0, 0, 1);
        do_reset("halt_rst", 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst", 1'b0);
            if ($urandom_range(0, 19) == 0) bus.pc = {$urandom(), 2'b00} >> 0;
            step("rnd",
                 ($urandom_range(0, 5) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 ($urandom_range(0, 7) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
